// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised true dual-port byte-writable RAM with post-reset zero-clear sequencer.
// Define RAM_COLLISION_FLAG_EN to add the sticky collision_o output.
module ram_dp_param #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8192,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    init_done_o,
  input  logic                    en_i_a,
  input  logic [ADDR_WIDTH-1:0]   addr_i_a,
  input  logic [DATA_WIDTH/8-1:0] we_i_a,
  input  logic [DATA_WIDTH-1:0]   data_i_a,
  output logic [DATA_WIDTH-1:0]   data_o_a,
  output logic                    valid_o_a,
  input  logic                    en_i_b,
  input  logic [ADDR_WIDTH-1:0]   addr_i_b,
  input  logic [DATA_WIDTH/8-1:0] we_i_b,
  input  logic [DATA_WIDTH-1:0]   data_i_b,
  output logic [DATA_WIDTH-1:0]   data_o_b,
  output logic                    valid_o_b
`ifdef RAM_COLLISION_FLAG_EN
  ,
  output logic                    collision_o
`endif
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IW    = $clog2(DEPTH);

  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      (READ_LATENCY != 1 && READ_LATENCY != 2) || ADDR_WIDTH < OFS + IW) begin : g_bad_param
    $fatal(1, "ram_dp_param: illegal DATA_WIDTH, DEPTH, ADDR_WIDTH or READ_LATENCY");
  end

  typedef enum logic {CLEAR, READY} state_e;

  state_e                       state_q, state_d;
  logic [IW-1:0]                cnt_q, cnt_d;
  logic [1:0]                   acc;
  logic [1:0][IW-1:0]           idx;
  logic [1:0][BYTES-1:0]        we;
  logic [1:0][DATA_WIDTH-1:0]   wd, old, rd;
  logic [1:0][DATA_WIDTH-1:0]   d1_q, d1_d, d2_q, d2_d;
  logic [1:0]                   v1_q, v1_d, v2_q, v2_d;
  logic                         unused_addr;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] o,
                                                  input logic [DATA_WIDTH-1:0] n,
                                                  input logic [BYTES-1:0] m);
    merge = o;
    for (int k = 0; k < BYTES; k++)
      if (m[k]) merge[8*k +: 8] = n[8*k +: 8];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  always_comb begin
    state_d = (state_q == CLEAR && cnt_q == IW'(DEPTH - 1)) ? READY : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
  end

  always_comb init_done_o = state_q == READY;

  always_comb begin
    acc         = {en_i_b, en_i_a} & {2{init_done_o}};
    idx[0]      = addr_i_a[OFS +: IW];
    idx[1]      = addr_i_b[OFS +: IW];
    we          = {we_i_b, we_i_a};
    wd          = {data_i_b, data_i_a};
    unused_addr = ^{addr_i_a, addr_i_b};
  end

  // One array per byte lane; port A's write is issued last so it wins a shared lane.
  for (genvar k = 0; k < BYTES; k++) begin : g_lane
    logic [7:0] lane_q [DEPTH];
    always_ff @(posedge clk_i)
      if (state_q == CLEAR) lane_q[cnt_q] <= '0;
      else begin
        if (acc[1] && we[1][k]) lane_q[idx[1]] <= wd[1][8*k +: 8];
        if (acc[0] && we[0][k]) lane_q[idx[0]] <= wd[0][8*k +: 8];
      end
    assign old[0][8*k +: 8] = lane_q[idx[0]];
    assign old[1][8*k +: 8] = lane_q[idx[1]];
  end

  // Write-first merges only the port's own lanes, so cross-port reads stay pre-cycle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]   = WRITE_FIRST != 0 ? merge(old[p], wd[p], we[p]) : old[p];
      v1_d[p] = acc[p];
      d1_d[p] = acc[p] ? rd[p] : d1_q[p];
      v2_d[p] = v1_q[p];
      d2_d[p] = v1_q[p] ? d1_q[p] : d2_q[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      v1_q <= '0;
      v2_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end

  always_comb begin
    data_o_a  = READ_LATENCY == 2 ? d2_q[0] : d1_q[0];
    data_o_b  = READ_LATENCY == 2 ? d2_q[1] : d1_q[1];
    valid_o_a = READ_LATENCY == 2 ? v2_q[0] : v1_q[0];
    valid_o_b = READ_LATENCY == 2 ? v2_q[1] : v1_q[1];
  end

`ifdef RAM_COLLISION_FLAG_EN
  logic coll_q, coll_d;

  always_comb coll_d = coll_q | (&acc && idx[0] == idx[1] && (|we[0] || |we[1]));

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) coll_q <= 1'b0;
    else coll_q <= coll_d;

  always_comb collision_o = coll_q;
`endif
endmodule
